// File: rtl/ppu_spr_dma.sv
// Sprite DMA initiator.
//
// A CPU write of a page number to DMA_REG_ADDR starts a 256-byte copy from CPU memory
// {page, 8'h00..8'hff} into OAM. Each byte goes through the PPU register interface as a
// write to OAM_DATA_SEL. The CPU is held off (cpu_rdy_out low) for the whole transfer, and
// the block owns the CPU memory bus while it is reading.
//
// Each byte takes three cycles:
//   StRd    - present the source address
//   StLatch - memory data becomes valid and is captured at the end of the cycle
//   StWr    - one-cycle ri_ncs_out strobe carrying the captured byte
//
// Ports:
//   clk_in        system clock; all logic runs on its rising edge
//   rst_in        synchronous active-low reset; an active transfer is aborted
//   cpu_a_in      CPU address bus (trigger decode)
//   cpu_d_in      CPU write data (source page on trigger)
//   cpu_r_nw_in   CPU read/write (0 = write)
//   mem_d_in      CPU memory read data, valid the cycle after mem_a_out is presented
//   cpu_rdy_out   CPU ready; low stalls the CPU during a transfer
//   mem_req_out   high while this block drives the CPU memory bus
//   mem_a_out     DMA source address
//   mem_r_nw_out  tied to 1; memory is only ever read
//   ri_sel_out    PPU register select (always OAM data)
//   ri_ncs_out    PPU register chip select, active-low, one cycle per byte
//   ri_r_nw_out   PPU register read/write (0 = write)
//   ri_d_out      PPU register write data
//   active_out    high while a transfer is in progress
//   done_out      one-cycle pulse when a transfer completes
//
// Every output comes straight from a register, so no input reaches an output
// combinationally.

module ppu_spr_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAM_DATA_SEL = 3'h4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] cpu_a_in,
  input  logic [7:0]  cpu_d_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  mem_d_in,
  output logic        cpu_rdy_out,
  output logic        mem_req_out,
  output logic [15:0] mem_a_out,
  output logic        mem_r_nw_out,
  output logic [2:0]  ri_sel_out,
  output logic        ri_ncs_out,
  output logic        ri_r_nw_out,
  output logic [7:0]  ri_d_out,
  output logic        active_out,
  output logic        done_out
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StLatch = 3'd2,
    StWr    = 3'd3
  } state_e;

  state_e      state_q;
  logic [7:0]  page_q;
  logic [7:0]  cnt_q;
  logic [7:0]  data_q;
  logic        done_q;

  // Output registers, loaded with the value matching the state being entered.
  logic        active_q;
  logic        mem_req_q;
  logic [15:0] mem_a_q;
  logic        ri_ncs_q;

  logic        trigger;
  assign trigger = !cpu_r_nw_in && (cpu_a_in == DMA_REG_ADDR);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= StIdle;
      page_q    <= 8'h00;
      cnt_q     <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      active_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_a_q   <= 16'h0000;
      ri_ncs_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Also taken in the done_out cycle, allowing back-to-back transfers.
          if (trigger) begin
            page_q    <= cpu_d_in;
            cnt_q     <= 8'h00;
            state_q   <= StRd;
            active_q  <= 1'b1;
            mem_req_q <= 1'b1;
            mem_a_q   <= {cpu_d_in, 8'h00};
          end
        end
        StRd: begin
          state_q <= StLatch;
        end
        StLatch: begin
          data_q    <= mem_d_in;
          state_q   <= StWr;
          mem_req_q <= 1'b0;
          ri_ncs_q  <= 1'b0;
        end
        StWr: begin
          ri_ncs_q <= 1'b1;
          // The last byte ends the transfer, so the counter never wraps.
          if (cnt_q == 8'hff) begin
            state_q  <= StIdle;
            done_q   <= 1'b1;
            active_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q + 8'd1;
            state_q   <= StRd;
            mem_req_q <= 1'b1;
            mem_a_q   <= {page_q, cnt_q + 8'd1};
          end
        end
        default: begin
          state_q   <= StIdle;
          active_q  <= 1'b0;
          mem_req_q <= 1'b0;
          ri_ncs_q  <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_rdy_out  = ~active_q;
  assign active_out   = active_q;
  assign mem_req_out  = mem_req_q;
  assign mem_a_out    = mem_a_q;
  assign mem_r_nw_out = 1'b1;
  assign ri_sel_out   = OAM_DATA_SEL;
  assign ri_ncs_out   = ri_ncs_q;
  // Chip select and write enable assert together, only in the write cycle.
  assign ri_r_nw_out  = ri_ncs_q;
  assign ri_d_out     = data_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_ppu_spr_dma.sv
module tb_ppu_spr_dma;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] cpu_a_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_r_nw_in;
  logic [7:0]  mem_d_in = 8'h00;
  logic        cpu_rdy_out;
  logic        mem_req_out;
  logic [15:0] mem_a_out;
  logic        mem_r_nw_out;
  logic [2:0]  ri_sel_out;
  logic        ri_ncs_out;
  logic        ri_r_nw_out;
  logic [7:0]  ri_d_out;
  logic        active_out;
  logic        done_out;

  ppu_spr_dma dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .cpu_a_in    (cpu_a_in),
    .cpu_d_in    (cpu_d_in),
    .cpu_r_nw_in (cpu_r_nw_in),
    .mem_d_in    (mem_d_in),
    .cpu_rdy_out (cpu_rdy_out),
    .mem_req_out (mem_req_out),
    .mem_a_out   (mem_a_out),
    .mem_r_nw_out(mem_r_nw_out),
    .ri_sel_out  (ri_sel_out),
    .ri_ncs_out  (ri_ncs_out),
    .ri_r_nw_out (ri_r_nw_out),
    .ri_d_out    (ri_d_out),
    .active_out  (active_out),
    .done_out    (done_out)
  );

  always #10 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Memory contents: page 02 holds nn ^ 8'h5a; other pages are xor-ed with (page ^ 8'h02).
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5a ^ a[15:8] ^ 8'h02;
  endfunction

  // Read data is valid the cycle after the address is presented.
  always @(posedge clk_in) mem_d_in <= mem_val(mem_a_out);

  // Cumulative observation counters, sampled on the falling edge.
  int          strobe_total = 0;
  int          bad_total    = 0;
  int          active_total = 0;
  int          done_total   = 0;
  int          zero_total   = 0;
  int          done_cyc     = -1;
  logic [7:0]  data_log [2048];
  logic [15:0] addr_log [2048];
  int          cyc_log  [2048];

  always @(negedge clk_in) begin
    if (active_out === 1'b1) active_total++;
    if (done_out === 1'b1) begin
      done_total++;
      done_cyc = cyc;
    end
    if (mem_req_out === 1'b1 && mem_a_out === 16'h0000) zero_total++;
    if (ri_ncs_out === 1'b0) begin
      data_log[strobe_total % 2048] = ri_d_out;
      addr_log[strobe_total % 2048] = mem_a_out;
      cyc_log[strobe_total % 2048]  = cyc;
      if (ri_sel_out !== 3'h4 || ri_r_nw_out !== 1'b0) bad_total++;
      strobe_total++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns t0 = cycle stamp of the first cycle after the trigger.
  task automatic trigger(input logic [7:0] page, output int t0);
    cpu_a_in    = 16'h4014;
    cpu_d_in    = page;
    cpu_r_nw_in = 1'b0;
    @(negedge clk_in);
    cpu_a_in    = 16'h0000;
    cpu_d_in    = 8'h00;
    cpu_r_nw_in = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic wait_done(input int base, input string tag);
    int n = 0;
    while (done_total == base && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    check(tag, 32'(done_total != base), 32'd1);
  endtask

  int t0, t1;
  int sb, ab, db, zb, bb;
  int addr_bad, data_bad;

  initial begin
    rst_in      = 1'b0;
    cpu_a_in    = 16'h0000;
    cpu_d_in    = 8'h00;
    cpu_r_nw_in = 1'b1;

    // Reset state
    repeat (5) @(negedge clk_in);
    check("rst_rdy",     32'(cpu_rdy_out),  32'd1);
    check("rst_ncs",     32'(ri_ncs_out),   32'd1);
    check("rst_active",  32'(active_out),   32'd0);
    check("rst_mem_req", 32'(mem_req_out),  32'd0);
    check("rst_done",    32'(done_out),     32'd0);
    check("rst_mem_a",   32'(mem_a_out),    32'h0000);
    check("rst_mem_rnw", 32'(mem_r_nw_out), 32'd1);
    check("rst_sel",     32'(ri_sel_out),   32'h4);
    check("rst_ri_rnw",  32'(ri_r_nw_out),  32'd1);
    check("rst_ri_d",    32'(ri_d_out),     32'h00);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Page 02 transfer
    sb = strobe_total; ab = active_total; db = done_total; bb = bad_total;
    trigger(8'h02, t0);
    check("p2_active_start", 32'(active_out), 32'd1);
    check("p2_rdy_low", 32'(cpu_rdy_out), 32'd0);
    wait_done(db, "p2_done_timeout");
    repeat (3) @(negedge clk_in);
    check("p2_strobes", 32'(strobe_total - sb), 32'd256);
    check("p2_bad_sel_rnw", 32'(bad_total - bb), 32'd0);
    check("p2_active_cycles", 32'(active_total - ab), 32'd768);
    check("p2_done_pulses", 32'(done_total - db), 32'd1);
    check("p2_done_cycle", 32'(done_cyc), 32'(t0 + 768));
    check("p2_first_strobe_cycle", 32'(cyc_log[sb]), 32'(t0 + 2));
    data_bad = 0;
    addr_bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (data_log[sb + k] !== (8'(k) ^ 8'h5a)) data_bad++;
      if (addr_log[sb + k] !== {8'h02, 8'(k)}) addr_bad++;
    end
    check("p2_data_order", 32'(data_bad), 32'd0);
    check("p2_addr_order", 32'(addr_bad), 32'd0);
    check("p2_idle_rdy", 32'(cpu_rdy_out), 32'd1);

    // Read of the DMA register, then a write to the neighbouring address
    ab = active_total; sb = strobe_total;
    cpu_a_in = 16'h4014; cpu_d_in = 8'h09; cpu_r_nw_in = 1'b1;
    @(negedge clk_in);
    cpu_a_in = 16'h4015; cpu_d_in = 8'h09; cpu_r_nw_in = 1'b0;
    @(negedge clk_in);
    cpu_a_in = 16'h0000; cpu_d_in = 8'h00; cpu_r_nw_in = 1'b1;
    repeat (5) @(negedge clk_in);
    check("notrig_active", 32'(active_total - ab), 32'd0);
    check("notrig_strobes", 32'(strobe_total - sb), 32'd0);

    // Re-trigger during an active transfer is ignored
    sb = strobe_total; db = done_total;
    trigger(8'h02, t0);
    wait_cyc(t0 + 99);
    cpu_a_in = 16'h4014; cpu_d_in = 8'h07; cpu_r_nw_in = 1'b0;
    @(negedge clk_in);
    cpu_a_in = 16'h0000; cpu_d_in = 8'h00; cpu_r_nw_in = 1'b1;
    wait_done(db, "retrig_done_timeout");
    repeat (3) @(negedge clk_in);
    check("retrig_strobes", 32'(strobe_total - sb), 32'd256);
    check("retrig_done_cycle", 32'(done_cyc), 32'(t0 + 768));
    addr_bad = 0;
    for (int k = 0; k < 256; k++) if (addr_log[sb + k] !== {8'h02, 8'(k)}) addr_bad++;
    check("retrig_addr_page", 32'(addr_bad), 32'd0);

    // Page ff, followed by a trigger in its done cycle
    sb = strobe_total; db = done_total; zb = zero_total;
    trigger(8'hff, t0);
    wait_cyc(t0 + 768);
    check("pff_done_high", 32'(done_out), 32'd1);
    cpu_a_in = 16'h4014; cpu_d_in = 8'h03; cpu_r_nw_in = 1'b0;
    @(negedge clk_in);
    cpu_a_in = 16'h0000; cpu_d_in = 8'h00; cpu_r_nw_in = 1'b1;
    t1 = cyc;
    check("pff_strobes", 32'(strobe_total - sb), 32'd256);
    check("pff_last_addr", 32'(addr_log[sb + 255]), 32'hffff);
    check("pff_first_addr", 32'(addr_log[sb]), 32'hff00);
    check("pff_no_zero_addr", 32'(zero_total - zb), 32'd0);
    check("b2b_active", 32'(active_out), 32'd1);
    check("b2b_mem_a", 32'(mem_a_out), 32'h0300);

    // Reset while byte 10 is in its write cycle
    sb = strobe_total; db = done_total;
    wait_cyc(t1 + 32);
    check("abort_byte10_strobe", 32'(ri_ncs_out), 32'd0);
    check("abort_byte10_data", 32'(ri_d_out), 32'(8'h0a ^ 8'h5a ^ 8'h01));
    rst_in = 1'b0;
    @(negedge clk_in);
    check("abort_active", 32'(active_out), 32'd0);
    check("abort_rdy", 32'(cpu_rdy_out), 32'd1);
    check("abort_ncs", 32'(ri_ncs_out), 32'd1);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (800) @(negedge clk_in);
    check("abort_strobes", 32'(strobe_total - sb), 32'd11);
    check("abort_no_done", 32'(done_total - db), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
